// File: rtl/vga_pkg.sv
// vga_pkg: shared defaults for the VGA sprite compositor.
// Used by both the compositor and its spr_hit channels, with or without SPR_FLIP_EN.
package vga_pkg;
  localparam int H_ACT_DEF = 640;
  localparam int V_ACT_DEF = 480;
  localparam int COLOR_W = 24;
  localparam logic [COLOR_W-1:0] KEY_DEF = 24'h000000;
endpackage

// File: rtl/spr_hit.sv
// spr_hit: one sprite channel - frame-start shadow registers, hit test and sprite ROM address.
// SPR_FLIP_EN adds a per-sprite horizontal mirror.
module spr_hit
  import vga_pkg::*;
#(
  parameter int SPR_W = 64,
  parameter int SPR_H = 64,
  localparam int AW = $clog2(SPR_W*SPR_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_cap,
  input  logic [9:0]    i_sx,
  input  logic [8:0]    i_sy,
  input  logic          i_en,
`ifdef SPR_FLIP_EN
  input  logic          i_flip,
`endif
  input  logic [9:0]    i_x,
  input  logic [8:0]    i_y,
  output logic          o_hit,
  output logic [AW-1:0] o_addr
);
  localparam int CW = $clog2(SPR_W);
  localparam int RW = $clog2(SPR_H);
  logic [9:0]    r_sx;
  logic [8:0]    r_sy;
  logic          r_en;
  logic          w_hit;
  logic [CW-1:0] w_col;
  // right/bottom edges are summed one bit wider so sprites near the edge clip instead of wrapping
  assign w_hit = r_en && i_x >= r_sx && {1'b0, i_x} < {1'b0, r_sx} + 11'(SPR_W)
              && i_y >= r_sy && {1'b0, i_y} < {1'b0, r_sy} + 10'(SPR_H);
`ifdef SPR_FLIP_EN
  logic r_flip;
  assign w_col = r_flip ? ~CW'(i_x - r_sx) : CW'(i_x - r_sx);
`else
  assign w_col = CW'(i_x - r_sx);
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sx   <= '0;
      r_sy   <= '0;
      r_en   <= 1'b0;
`ifdef SPR_FLIP_EN
      r_flip <= 1'b0;
`endif
      o_hit  <= 1'b0;
      o_addr <= '0;
    end else begin
      if (i_cap) begin
        r_sx   <= i_sx;
        r_sy   <= i_sy;
        r_en   <= i_en;
`ifdef SPR_FLIP_EN
        r_flip <= i_flip;
`endif
      end
      o_hit  <= w_hit;
      o_addr <= {RW'(i_y - r_sy), w_col};
    end
  end
endmodule

// File: rtl/vga_sprite_compositor.sv
// vga_sprite_compositor: overlays N_SPR colour-keyed sprites on a background ROM, 2-cycle latency.
// Define SPR_FLIP_EN to add the spr_flip horizontal mirror port.
module vga_sprite_compositor
  import vga_pkg::*;
#(
  parameter int N_SPR = 2,
  parameter int SPR_W = 64,
  parameter int SPR_H = 64,
  parameter int H_ACT = H_ACT_DEF,
  parameter int V_ACT = V_ACT_DEF,
  parameter logic [COLOR_W-1:0] KEY = KEY_DEF,
  localparam int AW = $clog2(SPR_W*SPR_H)
) (
  input  logic                     iVGA_CLK,
  input  logic                     iRST_n,
  input  logic                     iBLANK_n,
  input  logic                     iHS,
  input  logic                     iVS,
  input  logic [N_SPR*10-1:0]      spr_x,
  input  logic [N_SPR*9-1:0]       spr_y,
  input  logic [N_SPR-1:0]         spr_en,
`ifdef SPR_FLIP_EN
  input  logic [N_SPR-1:0]         spr_flip,
`endif
  output logic [18:0]              bg_addr,
  input  logic [COLOR_W-1:0]       bg_bgr,
  output logic [N_SPR*AW-1:0]      spr_addr,
  input  logic [N_SPR*COLOR_W-1:0] spr_bgr,
  output logic                     oBLANK_n,
  output logic                     oHS,
  output logic                     oVS,
  output logic [7:0]               b_data,
  output logic [7:0]               g_data,
  output logic [7:0]               r_data,
  output logic                     oFRAME
);
  logic [9:0]         r_x;
  logic [8:0]         r_y;
  logic [1:0]         r_hs, r_vs, r_bl;
  logic               r_armed;
  logic [COLOR_W-1:0] r_rgb, w_sel;
  logic [N_SPR-1:0]   w_hit;
  logic               w_cap;
  assign w_cap = r_vs[0] & ~iVS;
  for (genvar i = 0; i < N_SPR; i++) begin : g_spr
    spr_hit #(.SPR_W(SPR_W), .SPR_H(SPR_H)) u_hit (
      .clk    (iVGA_CLK),
      .rst_n  (iRST_n),
      .i_cap  (w_cap),
      .i_sx   (spr_x[i*10 +: 10]),
      .i_sy   (spr_y[i*9 +: 9]),
      .i_en   (spr_en[i]),
`ifdef SPR_FLIP_EN
      .i_flip (spr_flip[i]),
`endif
      .i_x    (r_x),
      .i_y    (r_y),
      .o_hit  (w_hit[i]),
      .o_addr (spr_addr[i*AW +: AW])
    );
  end
  // walk from the top channel down so the lowest opaque index wins
  always_comb begin
    w_sel = bg_bgr;
    for (int i = N_SPR - 1; i >= 0; i--)
      w_sel = (w_hit[i] && spr_bgr[i*COLOR_W +: COLOR_W] != KEY) ? spr_bgr[i*COLOR_W +: COLOR_W] : w_sel;
  end
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_x     <= '0;
      r_y     <= '0;
      bg_addr <= '0;
      r_hs    <= 2'b11;
      r_vs    <= 2'b11;
      r_bl    <= 2'b00;
      r_armed <= 1'b0;
      oFRAME  <= 1'b0;
      r_rgb   <= '0;
    end else begin
      r_x     <= iBLANK_n ? (r_x == 10'(H_ACT - 1) ? r_x : r_x + 1'b1) : '0;
      r_y     <= !iVS ? '0 : (r_bl[0] && !iBLANK_n && r_y != 9'(V_ACT - 1)) ? r_y + 1'b1 : r_y;
      bg_addr <= 19'(r_y) * 19'(H_ACT) + 19'(r_x);
      r_hs    <= {r_hs[0], iHS};
      r_vs    <= {r_vs[0], iVS};
      r_bl    <= {r_bl[0], iBLANK_n};
      r_armed <= r_armed | w_cap;
      oFRAME  <= w_cap;
      // stay black after reset until the first frame has captured fresh sprite state
      r_rgb   <= (r_bl[0] && r_armed) ? w_sel : '0;
    end
  end
  assign oHS = r_hs[1];
  assign oVS = r_vs[1];
  assign oBLANK_n = r_bl[1];
  assign {b_data, g_data, r_data} = r_rgb;
endmodule

// File: tb/tb_vga_sprite_compositor.sv
// tb_vga_sprite_compositor: drives synthetic video timing, models the composited picture per pixel
// from sprite geometry and ROM contents, and checks every output cycle plus directed pixels.
module tb_vga_sprite_compositor;
  localparam logic [23:0] KEY = 24'h000000;
  localparam int H = 640, V = 480, SW = 64, SH = 64;
  localparam logic [26:0] RST_V = {1'b1, 1'b1, 1'b0, 24'h0};
  localparam logic [23:0] GRN = 24'h00FF00, RED = 24'h0000FF;

  logic iVGA_CLK = 0, iRST_n = 0, iBLANK_n = 0, iHS = 1, iVS = 1;
  logic [19:0] spr_x = '0;
  logic [17:0] spr_y = '0;
  logic [1:0]  spr_en = '0;
`ifdef SPR_FLIP_EN
  logic [1:0]  spr_flip = '0;
`endif
  logic [18:0] bg_addr;
  logic [23:0] bg_bgr;
  logic [23:0] spr_addr;
  logic [47:0] spr_bgr;
  logic oBLANK_n, oHS, oVS, oFRAME;
  logic [7:0] b_data, g_data, r_data;

  int mode = 0;
  int n_chk = 0, n_pass = 0;
  typedef struct {logic [26:0] v; int x; int y; bit act;} ent_t;
  ent_t pipe[2];
  logic fr_exp = 0, prev_vs = 1, armed = 0;
  int sh_x[2], sh_y[2];
  bit sh_en[2], sh_fl[2];
  logic [23:0] obs[64][H];

  always #5 iVGA_CLK = ~iVGA_CLK;

  function automatic logic [23:0] bg_fn(input int unsigned a);
    return {5'h01, a[18:0]};
  endfunction

  function automatic logic [23:0] spr_fn(input int i, input int unsigned a, input int m);
    int unsigned h;
    h = a * 40503 + i * 7919 + 13;
    if (m == 0) return i == 0 ? GRN : RED;
    if (m == 1) return i == 0 ? ((a % 64 == 3) ? KEY : GRN) : RED;
    return (h % 5 == 0) ? KEY : (h[23:0] | 24'h1);
  endfunction

  // picture as defined by sprite rectangles, priority and colour key
  function automatic logic [23:0] ref_px(input int x, input int y);
    int c;
    logic [23:0] p;
    for (int i = 0; i < 2; i++)
      if (sh_en[i] && x >= sh_x[i] && x < sh_x[i] + SW && y >= sh_y[i] && y < sh_y[i] + SH) begin
        c = sh_fl[i] ? SW - 1 - (x - sh_x[i]) : x - sh_x[i];
        p = spr_fn(i, (y - sh_y[i]) * SW + c, mode);
        if (p != KEY) return p;
      end
    return bg_fn(y * H + x);
  endfunction

  function automatic logic [23:0] ob(input int y, input int x);
    return obs[y % 64][x];
  endfunction

  assign bg_bgr = bg_fn({13'b0, bg_addr});
  always_comb begin
    spr_bgr = '0;
    for (int i = 0; i < 2; i++) spr_bgr[i*24 +: 24] = spr_fn(i, {20'b0, spr_addr[i*12 +: 12]}, mode);
  end

  vga_sprite_compositor dut (
    .iVGA_CLK (iVGA_CLK), .iRST_n (iRST_n), .iBLANK_n (iBLANK_n), .iHS (iHS), .iVS (iVS),
    .spr_x (spr_x), .spr_y (spr_y), .spr_en (spr_en),
`ifdef SPR_FLIP_EN
    .spr_flip (spr_flip),
`endif
    .bg_addr (bg_addr), .bg_bgr (bg_bgr), .spr_addr (spr_addr), .spr_bgr (spr_bgr),
    .oBLANK_n (oBLANK_n), .oHS (oHS), .oVS (oVS),
    .b_data (b_data), .g_data (g_data), .r_data (r_data), .oFRAME (oFRAME)
  );

  task automatic check(input string tag, input logic [26:0] got, input logic [26:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got %h exp %h", tag, got, exp);
  endtask

  task automatic chk24(input string tag, input logic [23:0] got, input logic [23:0] exp);
    check(tag, {3'b0, got}, {3'b0, exp});
  endtask

  task automatic rst_check(input string tag);
    check({tag, "_out"}, {oHS, oVS, oBLANK_n, b_data, g_data, r_data}, RST_V);
    check({tag, "_frame"}, {26'b0, oFRAME}, 27'b0);
    check({tag, "_bg_addr"}, {8'b0, bg_addr}, 27'b0);
    check({tag, "_spr_addr"}, {3'b0, spr_addr}, 27'b0);
  endtask

  task automatic tick(input logic bl, input logic hs, input logic vs, input int x, input int y);
    @(negedge iVGA_CLK);
    check("pix", {oHS, oVS, oBLANK_n, b_data, g_data, r_data}, pipe[1].v);
    check("frame", {26'b0, oFRAME}, {26'b0, fr_exp});
    if (pipe[1].act) obs[pipe[1].y % 64][pipe[1].x] = {b_data, g_data, r_data};
    pipe[1] = pipe[0];
    fr_exp = prev_vs && !vs;
    if (fr_exp) begin
      armed = 1;
      for (int i = 0; i < 2; i++) begin
        sh_x[i] = int'(spr_x[i*10 +: 10]);
        sh_y[i] = int'(spr_y[i*9 +: 9]);
        sh_en[i] = spr_en[i];
`ifdef SPR_FLIP_EN
        sh_fl[i] = spr_flip[i];
`else
        sh_fl[i] = 0;
`endif
      end
    end
    prev_vs = vs;
    pipe[0].v = {hs, vs, bl, (bl && armed) ? ref_px(x, y) : 24'h0};
    pipe[0].x = x;
    pipe[0].y = y;
    pipe[0].act = bl;
    iBLANK_n = bl;
    iHS = hs;
    iVS = vs;
  endtask

  // short asynchronous pulse between clock edges, mid active line
  task automatic mid_reset();
    #1 iRST_n = 0;
    #1 rst_check("rst_mid");
    #1 iRST_n = 1;
    armed = 0;
    prev_vs = 1;
    fr_exp = 0;
    pipe[1].v = RST_V;
    pipe[1].act = 0;
    pipe[0].v[23:0] = 24'h0;
  endtask

  // lines outside [lo,hi] have only 3 active pixels so deep rows are reachable cheaply
  task automatic frame(input int lines, input int lo, input int hi, input int over,
                       input int rst_line, input int chg_line, input int chg_x);
    int len;
    for (int l = 0; l < 3; l++)
      for (int k = 0; k < 20; k++) tick(1'b0, !(k >= 2 && k < 6), l >= 2, 0, 0);
    for (int l = 0; l < lines; l++) begin
      len = (l >= lo && l <= hi) ? H + over : 3;
      for (int k = 0; k < len; k++) begin
        tick(1'b1, 1'b1, 1'b1, k < H ? k : H - 1, l < V ? l : V - 1);
        if (l == rst_line && k == H / 2) mid_reset();
      end
      for (int k = 0; k < 12; k++) tick(1'b0, !(k >= 2 && k < 8), 1'b1, 0, 0);
      if (l == chg_line) spr_x[9:0] = 10'(chg_x);
    end
  endtask

  initial begin
    int lo;
    for (int i = 0; i < 2; i++) begin
      pipe[i].v = RST_V;
      pipe[i].x = 0;
      pipe[i].y = 0;
      pipe[i].act = 0;
    end
    repeat (3) @(negedge iVGA_CLK);
    rst_check("rst_init");
    iRST_n = 1;
    repeat (10) tick(1'b0, 1'b1, 1'b1, 0, 0);

    mode = 2; spr_x = '0; spr_y = '0; spr_en = 2'b01;
    frame(6, 2, 3, 0, 3, -1, 0);
    chk24("black_after_rst", ob(3, 639), 24'h0);

    mode = 0; spr_x[9:0] = 10'd100; spr_y[8:0] = 9'd50; spr_en = 2'b01;
    frame(52, 49, 51, 0, -1, -1, 0);
    chk24("spr_100_50", ob(50, 100), GRN);
    chk24("spr_163_50", ob(50, 163), GRN);
    chk24("bg_99_50", ob(50, 99), bg_fn(50 * H + 99));
    chk24("bg_164_50", ob(50, 164), bg_fn(50 * H + 164));
    chk24("bg_100_49", ob(49, 100), bg_fn(49 * H + 100));

    mode = 1; spr_x = {10'd200, 10'd200}; spr_y = {9'd200, 9'd200}; spr_en = 2'b11;
    frame(202, 199, 201, 0, -1, -1, 0);
    chk24("key_col3", ob(200, 203), RED);
    chk24("key_col3_r1", ob(201, 203), RED);
    chk24("pri_col2", ob(200, 202), GRN);
    chk24("pri_col4", ob(200, 204), GRN);

    mode = 0; spr_x = {10'd0, 10'd100}; spr_y = {9'd0, 9'd10}; spr_en = 2'b01;
    frame(13, 9, 12, 0, -1, 10, 300);
    chk24("shadow_old_x", ob(11, 100), GRN);
    chk24("shadow_new_x", ob(11, 300), bg_fn(11 * H + 300));
    frame(13, 9, 12, 0, -1, -1, 0);
    chk24("next_new_x", ob(11, 300), GRN);
    chk24("next_old_x", ob(11, 100), bg_fn(11 * H + 100));
    chk24("next_299", ob(11, 299), bg_fn(11 * H + 299));

    spr_x[9:0] = 10'd600; spr_y[8:0] = 9'd5;
    frame(7, 4, 6, 0, -1, -1, 0);
    chk24("clip_600", ob(5, 600), GRN);
    chk24("clip_639", ob(5, 639), GRN);
    chk24("clip_599", ob(5, 599), bg_fn(5 * H + 599));
    chk24("nowrap_l5", ob(5, 0), bg_fn(5 * H));
    chk24("nowrap_l6", ob(6, 0), bg_fn(6 * H));

    spr_x[9:0] = 10'd600; spr_y[8:0] = 9'd470;
    frame(482, 477, 481, 10, -1, -1, 0);
    chk24("sat_479_639", ob(479, 639), GRN);
    chk24("sat_477_600", ob(477, 600), GRN);
    chk24("sat_477_599", ob(477, 599), bg_fn(477 * H + 599));

    mode = 2; spr_x = '0; spr_y[8:0] = 9'd3; spr_en = 2'b01;
`ifdef SPR_FLIP_EN
    spr_flip = 2'b01;
`endif
    frame(5, 3, 4, 0, -1, -1, 0);
`ifdef SPR_FLIP_EN
    chk24("flip_x0", ob(3, 0), spr_fn(0, 63, 2));
    spr_flip = '0;
`else
    chk24("noflip_x0", ob(3, 0), spr_fn(0, 0, 2));
`endif

    for (int f = 0; f < 3; f++) begin
      spr_x[9:0] = 10'($urandom_range(0, 700));
      spr_x[19:10] = f == 0 ? spr_x[9:0] + 10'($urandom_range(0, 40)) : 10'($urandom_range(0, 700));
      spr_y = {9'($urandom_range(0, 45)), 9'($urandom_range(0, 45))};
      spr_en = 2'($urandom_range(1, 3));
`ifdef SPR_FLIP_EN
      spr_flip = 2'($urandom);
`endif
      lo = $urandom_range(0, 30);
      frame(40, lo, lo + 3, $urandom_range(0, 3), -1, -1, 0);
    end
    repeat (4) tick(1'b0, 1'b1, 1'b1, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
